// File: rtl/dmem_if.sv
// Bundle of per-core request ports and shared data-memory port seen by the
// data-memory arbiter. The arbiter uses the slave view; cores/RAM use master.
interface dmem_if #(
    parameter int NUM_CORES = 4,
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 16
);
    logic [NUM_CORES-1:0]        req_rd;
    logic [NUM_CORES-1:0]        req_wr;
    logic [NUM_CORES*ADDR_W-1:0] req_addr;
    logic [NUM_CORES*DATA_W-1:0] req_wdata;
    logic [NUM_CORES-1:0]        core_ack;
    logic [DATA_W-1:0]           core_rdata;
    logic [ADDR_W-1:0]           mem_addr;
    logic [DATA_W-1:0]           mem_wdata;
    logic                        mem_read;
    logic                        mem_write;
    logic [DATA_W-1:0]           mem_rdata;
    logic                        busy;
    logic [2:0]                  grant_id;

    modport slave (
        input  req_rd, req_wr, req_addr, req_wdata, mem_rdata,
        output core_ack, core_rdata, mem_addr, mem_wdata, mem_read, mem_write,
               busy, grant_id
    );

    modport master (
        output req_rd, req_wr, req_addr, req_wdata, mem_rdata,
        input  core_ack, core_rdata, mem_addr, mem_wdata, mem_read, mem_write,
               busy, grant_id
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter/sequencer sharing one single-port data RAM among cores.
// One access at a time: IDLE (arbitrate) -> ISSUE (strobe) -> [WAIT] -> ACK.
// Every output is a register; strobes and ack are one-cycle pulses.
module dmem_arbiter #(
    parameter int NUM_CORES = 4,
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 16,
    parameter int MEM_LAT   = 1
) (
    input logic   clk,
    input logic   rst_n,
    dmem_if.slave bus
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;

    state_t               state_q, state_nx;
    logic [2:0]           last_q, last_nx;
    logic [2:0]           win_q, win_nx;
    logic                 wr_q, wr_nx;
    logic [2:0]           cnt_q, cnt_nx;
    logic [NUM_CORES-1:0] ack_q, ack_nx;
    logic [DATA_W-1:0]    rdata_q, rdata_nx;
    logic [ADDR_W-1:0]    addr_q, addr_nx;
    logic [DATA_W-1:0]    wdata_q, wdata_nx;
    logic                 rd_q, rd_nx;
    logic                 wrs_q, wrs_nx;
    logic                 busy_q, busy_nx;
    logic [2:0]           gid_q, gid_nx;

    logic [NUM_CORES-1:0] reqv;
    logic [NUM_CORES-1:0] wr_sh;
    int                   sel;

    assign reqv = bus.req_rd | bus.req_wr;

    // Nearest requester after 'last' (wrapping); 'last' itself is checked
    // last so the most recently served core has lowest priority. -1 if none.
    function automatic int rr_pick(input logic [NUM_CORES-1:0] r,
                                   input logic [2:0] last);
        int                   idx;
        logic [NUM_CORES-1:0] sh;
        rr_pick = -1;
        for (int k = NUM_CORES; k >= 1; k--) begin
            idx = (int'(last) + k) % NUM_CORES;
            sh  = r >> idx;
            if (sh[0]) rr_pick = idx;
        end
    endfunction

    // Next-state and next-output logic for the access sequencer.
    always_comb begin
        state_nx = state_q;
        last_nx  = last_q;
        win_nx   = win_q;
        wr_nx    = wr_q;
        cnt_nx   = cnt_q;
        ack_nx   = '0;
        rdata_nx = rdata_q;
        addr_nx  = addr_q;
        wdata_nx = wdata_q;
        rd_nx    = 1'b0;
        wrs_nx   = 1'b0;
        gid_nx   = gid_q;
        wr_sh    = '0;
        sel      = rr_pick(reqv, last_q);

        case (state_q)
            IDLE: begin
                if (sel >= 0) begin
                    // Address/data go straight into the output registers so
                    // they are already on the memory bus in the ISSUE cycle.
                    wr_sh    = bus.req_wr >> sel;
                    win_nx   = 3'(sel);
                    last_nx  = 3'(sel);
                    gid_nx   = 3'(sel);
                    wr_nx    = wr_sh[0];
                    addr_nx  = ADDR_W'(bus.req_addr >> (sel * ADDR_W));
                    wdata_nx = DATA_W'(bus.req_wdata >> (sel * DATA_W));
                    rd_nx    = ~wr_sh[0];
                    wrs_nx   = wr_sh[0];
                    state_nx = ISSUE;
                end
            end
            ISSUE: begin
                if (wr_q) begin
                    ack_nx   = NUM_CORES'(1) << win_q;
                    state_nx = ACK;
                end else begin
                    cnt_nx   = '0;
                    state_nx = WAIT;
                end
            end
            WAIT: begin
                // cnt_q counts WAIT cycles already spent; the last one is
                // MEM_LAT cycles after ISSUE, when mem_rdata is valid.
                if (cnt_q == 3'(MEM_LAT - 1)) begin
                    rdata_nx = bus.mem_rdata;
                    ack_nx   = NUM_CORES'(1) << win_q;
                    state_nx = ACK;
                end else begin
                    cnt_nx = cnt_q + 3'd1;
                end
            end
            ACK: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase

        busy_nx = (state_nx != IDLE);
    end

    // State and registered outputs; reset abandons any in-flight access.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            last_q  <= 3'(NUM_CORES - 1);
            win_q   <= '0;
            wr_q    <= 1'b0;
            cnt_q   <= '0;
            ack_q   <= '0;
            rdata_q <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rd_q    <= 1'b0;
            wrs_q   <= 1'b0;
            busy_q  <= 1'b0;
            gid_q   <= '0;
        end else begin
            state_q <= state_nx;
            last_q  <= last_nx;
            win_q   <= win_nx;
            wr_q    <= wr_nx;
            cnt_q   <= cnt_nx;
            ack_q   <= ack_nx;
            rdata_q <= rdata_nx;
            addr_q  <= addr_nx;
            wdata_q <= wdata_nx;
            rd_q    <= rd_nx;
            wrs_q   <= wrs_nx;
            busy_q  <= busy_nx;
            gid_q   <= gid_nx;
        end
    end

    assign bus.core_ack   = ack_q;
    assign bus.core_rdata = rdata_q;
    assign bus.mem_addr   = addr_q;
    assign bus.mem_wdata  = wdata_q;
    assign bus.mem_read   = rd_q;
    assign bus.mem_write  = wrs_q;
    assign bus.busy       = busy_q;
    assign bus.grant_id   = gid_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: one instance with MEM_LAT=1 and one with MEM_LAT=3,
// each with a small RAM model whose read data is 0xDEAD outside its valid cycle.
module tb_dmem_arbiter;

    typedef struct {
        logic [3:0]  ack;
        logic [15:0] rdata;
        bit          chk;
    } exp_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   checks;
    int   errors;
    int   c0;

    exp_t       sb[$];
    exp_t       sb3[$];
    int         strobe_cyc[$];
    logic [2:0] strobe_gid[$];
    int         ack_cyc[$];
    int         ack3_cyc[$];
    int         strobe3_cyc[$];

    logic [15:0] mem1 [0:255];
    logic [15:0] mem3 [0:255];
    logic [15:0] st1;
    logic [15:0] st3 [0:2];
    logic        bd_we;
    logic [7:0]  bd_addr;
    logic [15:0] bd_data;

    dmem_if #(.NUM_CORES(4), .ADDR_W(16), .DATA_W(16)) b1();
    dmem_if #(.NUM_CORES(4), .ADDR_W(16), .DATA_W(16)) b3();

    dmem_arbiter #(.NUM_CORES(4), .ADDR_W(16), .DATA_W(16), .MEM_LAT(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(b1)
    );
    dmem_arbiter #(.NUM_CORES(4), .ADDR_W(16), .DATA_W(16), .MEM_LAT(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .bus(b3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // RAM models: backdoor preload, writes at the strobe edge, reads delayed.
    always @(posedge clk) begin
        if (bd_we) begin
            mem1[bd_addr] <= bd_data;
            mem3[bd_addr] <= bd_data;
        end else begin
            if (b1.mem_write) mem1[b1.mem_addr[7:0]] <= b1.mem_wdata;
            if (b3.mem_write) mem3[b3.mem_addr[7:0]] <= b3.mem_wdata;
        end
        st1    <= b1.mem_read ? mem1[b1.mem_addr[7:0]] : 16'hDEAD;
        st3[0] <= b3.mem_read ? mem3[b3.mem_addr[7:0]] : 16'hDEAD;
        st3[1] <= st3[0];
        st3[2] <= st3[1];
    end
    assign b1.mem_rdata = st1;
    assign b3.mem_rdata = st3[2];

    // Monitor for the MEM_LAT=1 instance.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (b1.mem_read || b1.mem_write) begin
                strobe_cyc.push_back(cyc);
                strobe_gid.push_back(b1.grant_id);
                checks++;
                if (b1.mem_read && b1.mem_write) begin
                    errors++;
                    $display("FAIL strobe_excl: read=%0b write=%0b, required not both high",
                             b1.mem_read, b1.mem_write);
                end
            end
            if (b1.core_ack != 4'b0) begin
                ack_cyc.push_back(cyc);
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL ack_unexpected: core_ack=%b at cycle %0d, required no ack",
                             b1.core_ack, cyc);
                end else begin
                    e = sb.pop_front();
                    if (b1.core_ack !== e.ack || (e.chk && b1.core_rdata !== e.rdata)) begin
                        errors++;
                        $display("FAIL ack: got ack=%b rdata=0x%h, required ack=%b rdata=0x%h",
                                 b1.core_ack, b1.core_rdata, e.ack, e.rdata);
                    end
                end
            end
        end
    end

    // Monitor for the MEM_LAT=3 instance.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (b3.mem_read || b3.mem_write) strobe3_cyc.push_back(cyc);
            if (b3.core_ack != 4'b0) begin
                ack3_cyc.push_back(cyc);
                checks++;
                if (sb3.size() == 0) begin
                    errors++;
                    $display("FAIL ack3_unexpected: core_ack=%b, required no ack", b3.core_ack);
                end else begin
                    e = sb3.pop_front();
                    if (b3.core_ack !== e.ack || (e.chk && b3.core_rdata !== e.rdata)) begin
                        errors++;
                        $display("FAIL ack3: got ack=%b rdata=0x%h, required ack=%b rdata=0x%h",
                                 b3.core_ack, b3.core_rdata, e.ack, e.rdata);
                    end
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_ack"},   32'(b1.core_ack),   32'h0);
        chk({tag, "_rdata"}, 32'(b1.core_rdata), 32'h0);
        chk({tag, "_addr"},  32'(b1.mem_addr),   32'h0);
        chk({tag, "_wdata"}, 32'(b1.mem_wdata),  32'h0);
        chk({tag, "_read"},  32'(b1.mem_read),   32'h0);
        chk({tag, "_write"}, 32'(b1.mem_write),  32'h0);
        chk({tag, "_busy"},  32'(b1.busy),       32'h0);
        chk({tag, "_gid"},   32'(b1.grant_id),   32'h0);
    endtask

    task automatic backdoor(input logic [7:0] a, input logic [15:0] d);
        bd_addr = a;
        bd_data = d;
        bd_we   = 1'b1;
        @(posedge clk);
        #1;
        bd_we   = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Let DUT1 run until n acks; each acked core drops its request on the
    // edge that ends its ack cycle.
    task automatic serve1(input int n, input int budget);
        int got;
        int k;
        logic [3:0] a;
        got = 0;
        k   = 0;
        while (got < n && k < budget) begin
            @(negedge clk);
            k++;
            if (b1.core_ack != 4'b0) begin
                a = b1.core_ack;
                got++;
                @(posedge clk);
                #1;
                b1.req_rd = b1.req_rd & ~a;
                b1.req_wr = b1.req_wr & ~a;
            end
        end
        checks++;
        if (got < n) begin
            errors++;
            $display("FAIL serve_timeout: got %0d acks, required %0d", got, n);
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        bd_we       = 1'b0;
        bd_addr     = '0;
        bd_data     = '0;
        checks      = 0;
        errors      = 0;
        cyc         = 0;
        b1.req_rd   = '0;
        b1.req_wr   = '0;
        b1.req_addr = '0;
        b1.req_wdata = '0;
        b3.req_rd   = '0;
        b3.req_wr   = '0;
        b3.req_addr = '0;
        b3.req_wdata = '0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_zero("reset");
        @(posedge clk);
        #1;
        backdoor(8'h10, 16'h1234);
        backdoor(8'h55, 16'h5A5A);
        backdoor(8'h60, 16'h0BAD);
        backdoor(8'h61, 16'h0C0D);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single read by core 0, MEM_LAT=1
        strobe_cyc.delete();
        ack_cyc.delete();
        sb.push_back('{4'b0001, 16'h1234, 1'b1});
        b1.req_addr[15:0] = 16'h0010;
        b1.req_rd[0] = 1'b1;
        c0 = cyc;
        @(posedge clk);
        #1;
        chk("t1_busy_issue", 32'(b1.busy), 32'h1);
        serve1(1, 20);
        chk("t1_strobe_cyc", 32'(strobe_cyc[0]), 32'(c0 + 1));
        chk("t1_ack_cyc", 32'(ack_cyc[0]), 32'(c0 + 3));
        chk("t1_busy_idle", 32'(b1.busy), 32'h0);

        // Four simultaneous writes right after reset
        do_reset();
        strobe_cyc.delete();
        strobe_gid.delete();
        for (int i = 0; i < 4; i++) begin
            b1.req_addr[i*16 +: 16]  = 16'h0020 + 16'(i);
            b1.req_wdata[i*16 +: 16] = 16'hA000 + 16'(i);
        end
        sb.push_back('{4'b0001, 16'h0, 1'b0});
        sb.push_back('{4'b0010, 16'h0, 1'b0});
        sb.push_back('{4'b0100, 16'h0, 1'b0});
        sb.push_back('{4'b1000, 16'h0, 1'b0});
        b1.req_wr = 4'b1111;
        c0 = cyc;
        serve1(4, 60);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t2_strobe_cyc%0d", i), 32'(strobe_cyc[i]), 32'(c0 + 1 + 3*i));
            chk($sformatf("t2_gid%0d", i), 32'(strobe_gid[i]), 32'(i));
        end
        chk("t2_mem20", 32'(mem1[8'h20]), 32'hA000);
        chk("t2_mem23", 32'(mem1[8'h23]), 32'hA003);

        // Fairness: core 2, then cores 0 and 3 together
        strobe_gid.delete();
        sb.push_back('{4'b0100, 16'h0, 1'b0});
        b1.req_addr[32 +: 16]  = 16'h0030;
        b1.req_wdata[32 +: 16] = 16'h3333;
        b1.req_wr[2] = 1'b1;
        serve1(1, 20);
        sb.push_back('{4'b1000, 16'h0, 1'b0});
        sb.push_back('{4'b0001, 16'h0, 1'b0});
        b1.req_wr = 4'b1001;
        serve1(2, 30);
        chk("t3_gid_first", 32'(strobe_gid[1]), 32'h3);
        chk("t3_gid_second", 32'(strobe_gid[2]), 32'h0);

        // Write 0xBEEF to 0x0042 by core 1, read back by core 3
        sb.push_back('{4'b0010, 16'h0, 1'b0});
        b1.req_addr[16 +: 16]  = 16'h0042;
        b1.req_wdata[16 +: 16] = 16'hBEEF;
        b1.req_wr[1] = 1'b1;
        serve1(1, 20);
        chk("t4_mem42", 32'(mem1[8'h42]), 32'hBEEF);
        sb.push_back('{4'b1000, 16'hBEEF, 1'b1});
        b1.req_addr[48 +: 16] = 16'h0042;
        b1.req_rd[3] = 1'b1;
        serve1(1, 20);

        // MEM_LAT=3 read by core 2 on the second instance
        strobe3_cyc.delete();
        ack3_cyc.delete();
        sb3.push_back('{4'b0100, 16'h5A5A, 1'b1});
        b3.req_addr[32 +: 16] = 16'h0055;
        b3.req_rd[2] = 1'b1;
        c0 = cyc;
        for (int k = 0; k < 20 && ack3_cyc.size() == 0; k++) begin
            @(posedge clk);
            #1;
        end
        b3.req_rd = '0;
        chk("t5_strobe_cyc", 32'(strobe3_cyc[0]), 32'(c0 + 1));
        chk("t5_ack_cyc", 32'(ack3_cyc[0]), 32'(c0 + 5));

        // Reset during WAIT abandons the read
        ack_cyc.delete();
        b1.req_addr[16 +: 16] = 16'h0060;
        b1.req_rd[1] = 1'b1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        b1.req_rd = '0;
        @(posedge clk);
        @(negedge clk);
        check_zero("t6_rst");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("t6_no_ack", 32'(ack_cyc.size()), 32'h0);

        // Fresh requests after reset: core 0 ahead of core 2
        strobe_gid.delete();
        sb.push_back('{4'b0001, 16'h0BAD, 1'b1});
        sb.push_back('{4'b0100, 16'h0C0D, 1'b1});
        b1.req_addr[0 +: 16]  = 16'h0060;
        b1.req_addr[32 +: 16] = 16'h0061;
        b1.req_rd = 4'b0101;
        serve1(2, 30);
        chk("t6_gid_first", 32'(strobe_gid[0]), 32'h0);

        chk("sb_empty", 32'(sb.size()), 32'h0);
        chk("sb3_empty", 32'(sb3.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
